// File: rtl/scan_decoder_if.sv
// Signal bundle for scan_decoder: decode/scan controls in, registered one-hot output and
// scan status out.
interface scan_decoder_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] dout;
  logic             dout_vld;
  logic [SEL_W-1:0] scan_idx;
  logic             wrap;

  modport master (
    output en, mode, load, sel,
    input  dout, dout_vld, scan_idx, wrap
  );

  modport slave (
    input  en, mode, load, sel,
    output dout, dout_vld, scan_idx, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// One-hot decoder with direct (load-captured) and auto-scan modes.
// Scan mode, dwell counter and wrap pulse exist only when SCAN_DECODER_SCAN_EN is defined.
module scan_decoder #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  scan_decoder_if.slave bus
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  if (SEL_W < 1 || SEL_W > 6 || DWELL < 1) begin : g_bad_param
    $error("scan_decoder: illegal SEL_W or DWELL");
  end

`ifdef SCAN_DECODER_SCAN_EN
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;
`else
  typedef enum logic [1:0] {IDLE, DIRECT} state_e;
`endif

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    return OUT_W'(1) << idx;
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] idx_q, idx_d;
`ifdef SCAN_DECODER_SCAN_EN
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             wrap_q, wrap_d;
`endif

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
`ifdef SCAN_DECODER_SCAN_EN
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
`endif
    if (!bus.en) begin
      state_d = IDLE;
      dout_d  = '0;
      vld_d   = 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
      dwell_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE, DIRECT: begin
`ifdef SCAN_DECODER_SCAN_EN
          if (bus.mode) begin
            state_d = SCAN;
            dout_d  = decode(bus.sel);
            vld_d   = 1'b1;
            idx_d   = bus.sel;
            dwell_d = '0;
          end else
`endif
          if (bus.load) begin
            state_d = DIRECT;
            dout_d  = decode(bus.sel);
            vld_d   = 1'b1;
            idx_d   = bus.sel;
          end
        end
`ifdef SCAN_DECODER_SCAN_EN
        SCAN: begin
          // Leaving scan keeps the last shown index on dout until a fresh load.
          if (!bus.mode) begin
            state_d = DIRECT;
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = idx_q + SEL_W'(1);
            dout_d  = decode(idx_q + SEL_W'(1));
            wrap_d  = (idx_q == '1);
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
`ifdef SCAN_DECODER_SCAN_EN
      dwell_q <= '0;
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
`ifdef SCAN_DECODER_SCAN_EN
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.scan_idx = idx_q;
`ifdef SCAN_DECODER_SCAN_EN
  assign bus.wrap     = wrap_q;
`else
  assign bus.wrap     = 1'b0;
`endif
endmodule
